fixed_div_iter: RTL and testbench

Multi-cycle sign-magnitude fixed-point divider for the spiking-neuron datapath. It computes a/b, or 1/b in reciprocal mode, exactly to truncation. It replaces the combinational Newton-Raphson reciprocal-times-multiply path in timing-critical neuron update stages. The divider sits between the membrane/conductance arithmetic and the state registers, using a valid/ready handshake on both sides so it can be shared across neurons.

---
 rtl/fixed_div_iter_if.sv | 26 ++
 rtl/fixed_div_iter.sv | 109 ++++++++++
 tb/tb_fixed_div_iter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_div_iter_if.sv
// Operand/result handshake bundle for fixed_div_iter.
// master = producer/consumer side, slave = the divider.
interface fixed_div_iter_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         overflow;
    logic         div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_data, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_data, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_div_iter.sv
// Sign-magnitude Q-format divider (a/b, or 1/b when op=1): restoring radix-2,
// one quotient bit per cycle, saturating on overflow and on a zero divisor.
module fixed_div_iter #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input logic             clk,
    input logic             reset,
    fixed_div_iter_if.slave bus
);
    localparam int ITER = N - 1 + Q;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]  LAST  = CW'(ITER - 1);
    localparam logic [N-2:0]   ONE_Q = (N-1)'(1) << Q;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    // Dividend bits leave the top of quot while quotient bits enter at the bottom,
    // so after ITER steps the register holds the full quotient.
    logic [ITER-1:0] quot;
    logic [N-2:0]    rem;
    logic [N-2:0]    dvsr;
    logic [CW-1:0]   cnt;
    logic            sign;

    logic            accept;
    logic [N-2:0]    b_mag;
    logic [N-2:0]    dvd_in;
    logic            sign_in;
    logic [N-1:0]    rem_shift;
    logic [N-2:0]    rem_sub;
    logic            ge;
    logic [ITER-1:0] q_next;
    logic            ovf;
    logic [N-2:0]    mag;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign b_mag         = bus.b[N-2:0];
    assign dvd_in        = bus.op ? ONE_Q : bus.a[N-2:0];
    assign sign_in       = bus.op ? bus.b[N-1] : (bus.a[N-1] ^ bus.b[N-1]);

    // Remainder stays below the divisor, so N-1 stored bits suffice; the
    // subtraction only matters when ge, where the result fits in N-1 bits.
    assign rem_shift = {rem, quot[ITER-1]};
    assign ge        = rem_shift >= {1'b0, dvsr};
    assign rem_sub   = rem_shift[N-2:0] - dvsr;
    assign q_next    = {quot[ITER-2:0], ge};
    assign ovf       = |q_next[ITER-1:N-1];
    assign mag       = ovf ? '1 : q_next[N-2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (b_mag == '0) ? DONE : BUSY;
            BUSY: if (cnt == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quot            <= '0;
            rem             <= '0;
            dvsr            <= '0;
            cnt             <= '0;
            sign            <= 1'b0;
            bus.out_data    <= '0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quot <= {dvd_in, {Q{1'b0}}};
                        rem  <= '0;
                        dvsr <= b_mag;
                        cnt  <= '0;
                        sign <= sign_in;
                        if (b_mag == '0) begin
                            bus.out_data    <= {sign_in, {(N-1){1'b1}}};
                            bus.overflow    <= 1'b0;
                            bus.div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    rem  <= ge ? rem_sub : rem_shift[N-2:0];
                    quot <= q_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.out_data    <= {sign & (|mag), mag};
                        bus.overflow    <= ovf;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_div_iter.sv
// Self-checking bench for fixed_div_iter (N=32, Q=16): directed vectors,
// randomized operands against an arithmetic model, handshake and reset scenarios.
module tb_fixed_div_iter;
    localparam int N    = 32;
    localparam int Q    = 16;
    localparam int ITER = N - 1 + Q;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    fixed_div_iter_if #(.N(N)) bus ();

    fixed_div_iter #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Returns {div_by_zero, overflow, out_data} from plain integer division.
    function automatic logic [33:0] model(input logic o, input logic [31:0] av, input logic [31:0] bv);
        longint unsigned num, den, quo;
        logic            s;
        logic [30:0]     m;
        logic            of;
        den = longint'(bv[30:0]);
        num = o ? (64'd1 << Q) : longint'(av[30:0]);
        s   = o ? bv[31] : (av[31] ^ bv[31]);
        if (den == 0) return {1'b1, 1'b0, s, 31'h7FFF_FFFF};
        quo = (num << Q) / den;
        if (quo > 64'h7FFF_FFFF) begin
            of = 1'b1;
            m  = '1;
        end else begin
            of = 1'b0;
            m  = quo[30:0];
        end
        if (m == 0) s = 1'b0;
        return {1'b0, of, s, m};
    endfunction

    // Drives one transaction; reports the result and the number of edges after
    // the accepting edge before out_valid was seen (200 means it never came).
    task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] d, output logic of, output logic dz, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.op = o; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        d = bus.out_data; of = bus.overflow; dz = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passes++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else passes++;
        checks++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); else passes++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[10], vb[10], vexp[10];
        logic        vop[10], vof[10], vdz[10];
        logic [31:0] d;
        logic        of, dz;
        int          lat, want_lat;
        va = '{32'h0006_0000, 32'h8001_8000, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
               32'h4000_0000, 32'h8001_0000, 32'h8000_0000, 32'h0003_0000};
        vb = '{32'h0002_0000, 32'h0000_8000, 32'h8003_0000, 32'h0004_0000, 32'h0003_0000, 32'h8000_8000,
               32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h0003_0000};
        vop = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        vexp = '{32'h0003_0000, 32'h8003_0000, 32'h0000_0000, 32'h0000_4000, 32'h0000_5555, 32'h8002_0000,
                 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000};
        vof = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vdz = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            run_op(vop[i], va[i], vb[i], d, of, dz, lat);
            want_lat = vdz[i] ? 0 : ITER;
            checks++; if (d !== vexp[i]) $display("FAIL dir%0d_data: got %h want %h", i, d, vexp[i]); else passes++;
            checks++; if (of !== vof[i]) $display("FAIL dir%0d_overflow: got %b want %b", i, of, vof[i]); else passes++;
            checks++; if (dz !== vdz[i]) $display("FAIL dir%0d_dbz: got %b want %b", i, dz, vdz[i]); else passes++;
            checks++; if (lat !== want_lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat); else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, d;
        logic        o, of, dz;
        logic [33:0] exp_r;
        int          lat, sel;
        for (int i = 0; i < 40; i++) begin
            o   = ($urandom_range(0, 3) == 0);
            av  = $urandom >> $urandom_range(0, 20);
            av[31] = 1'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      bv = {1'($urandom), 31'h0};
            else if (sel == 1) bv = {1'($urandom), 31'($urandom_range(1, 255))};
            else begin
                bv = $urandom >> $urandom_range(1, 24);
                if (bv[30:0] == 0) bv = 32'h1;
                bv[31] = 1'($urandom);
            end
            exp_r = model(o, av, bv);
            run_op(o, av, bv, d, of, dz, lat);
            checks++; if (d !== exp_r[31:0]) $display("FAIL rnd%0d_data: op=%b a=%h b=%h got %h want %h", i, o, av, bv, d, exp_r[31:0]); else passes++;
            checks++; if ({dz, of} !== exp_r[33:32]) $display("FAIL rnd%0d_flags: got dz=%b ov=%b want dz=%b ov=%b", i, dz, of, exp_r[33], exp_r[32]); else passes++;
            checks++; if (lat !== (exp_r[33] ? 0 : ITER)) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_r[33] ? 0 : ITER); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        int          w, bad_data, bad_ready, bad_valid;
        bus.op = 1'b0; bus.a = 32'h0006_0000; bus.b = 32'h0002_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 200) begin
            @(posedge clk); #1; w++;
        end
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_reach_done: got out_valid=%b want 1", bus.out_valid); else passes++;
        d0 = bus.out_data;
        bad_data = 0; bad_ready = 0; bad_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_data !== d0) bad_data++;
            if (bus.in_ready !== 1'b0) bad_ready++;
            if (bus.out_valid !== 1'b1) bad_valid++;
        end
        checks++; if (bad_data != 0) $display("FAIL bp_data_stable: got %0d changed cycles want 0", bad_data); else passes++;
        checks++; if (bad_ready != 0) $display("FAIL bp_in_ready_low: got %0d high cycles want 0", bad_ready); else passes++;
        checks++; if (bad_valid != 0) $display("FAIL bp_valid_held: got %0d dropped cycles want 0", bad_valid); else passes++;
        checks++; if (d0 !== 32'h0003_0000) $display("FAIL bp_data: got %h want 00030000", d0); else passes++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_after: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_out_valid_after: got %b want 0", bus.out_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp_q[$];
        logic [33:0] e;
        logic        r, ov, of, dz;
        logic [31:0] d;
        int          accepts, outs, last_acc, min_gap, overlap, bad;
        accepts = 0; outs = 0; last_acc = -1; min_gap = 1000; overlap = 0; bad = 0;
        bus.out_ready = 1'b1;
        bus.op = 1'b0; bus.a = 32'h0006_0000; bus.b = 32'h0002_0000; bus.in_valid = 1'b1;
        for (int c = 0; c < 400 && outs < 4; c++) begin
            r = bus.in_ready; ov = bus.out_valid; d = bus.out_data; of = bus.overflow; dz = bus.div_by_zero;
            if (r && ov) overlap++;
            if (r) exp_q.push_back(model(bus.op, bus.a, bus.b));
            @(posedge clk); #1;
            if (r) begin
                if (last_acc >= 0 && (c - last_acc) < min_gap) min_gap = c - last_acc;
                last_acc = c;
                accepts++;
                bus.op = 1'($urandom);
                bus.a = $urandom >> 8;
                bus.b = ($urandom >> 12) | 32'h1;
            end
            if (ov) begin
                outs++;
                if (exp_q.size() == 0) bad++;
                else begin
                    e = exp_q.pop_front();
                    if ({dz, of, d} !== e) begin
                        bad++;
                        $display("FAIL b2b_result%0d: got %h dz=%b ov=%b want %h dz=%b ov=%b", outs, d, dz, of, e[31:0], e[33], e[32]);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (outs != 4) $display("FAIL b2b_outputs: got %0d want 4", outs); else passes++;
        checks++; if (accepts != 4) $display("FAIL b2b_accepts: got %0d want 4", accepts); else passes++;
        checks++; if (bad != 0) $display("FAIL b2b_results: got %0d wrong want 0", bad); else passes++;
        checks++; if (overlap != 0) $display("FAIL b2b_ready_in_done: got %0d cycles want 0", overlap); else passes++;
        checks++; if (min_gap < ITER + 1) $display("FAIL b2b_gap: got %0d want >= %0d", min_gap, ITER + 1); else passes++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        logic        of, dz;
        int          lat, seen;
        bus.op = 1'b0; bus.a = 32'h0006_0000; bus.b = 32'h0002_0000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); else passes++;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
        end
        checks++; if (seen != 0) $display("FAIL abort_stays_idle: got %0d busy cycles want 0", seen); else passes++;
        run_op(1'b0, 32'h0006_0000, 32'h0002_0000, d, of, dz, lat);
        checks++; if (d !== 32'h0003_0000) $display("FAIL abort_next_data: got %h want 00030000", d); else passes++;
        checks++; if ({dz, of} !== 2'b00) $display("FAIL abort_next_flags: got %b want 00", {dz, of}); else passes++;
        checks++; if (lat !== ITER) $display("FAIL abort_next_latency: got %0d want %0d", lat, ITER); else passes++;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
